// File: rtl/exp_req_sched.sv
// exp_req_sched: round-robin sharing of one pipelined exp unit among N_REQ requesters
module exp_req_sched #(
  parameter int N_REQ   = 4,
  parameter int wTn     = 6,
  parameter int wTd     = 6,
  parameter int wRES    = 8,
  parameter int EXP_LAT = 8,
  parameter int MAX_OUT = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*wTn-1:0]   req_tn,
  input  logic [N_REQ*wTd-1:0]   req_td,
  output logic                   exp_req,
  output logic [wTn-1:0]         exp_tn,
  output logic [wTd-1:0]         exp_td,
  input  logic [wRES-1:0]        exp_result,
  output logic [N_REQ-1:0]       rsp_valid,
  output logic [wRES-1:0]        rsp_result,
  output logic                   idle
);
  localparam int PW = $clog2(N_REQ);
  localparam int CW = $clog2(MAX_OUT + 1);
  logic [PW-1:0]    ptr, g, idx;
  logic [CW-1:0]    cnt [N_REQ];
  logic [N_REQ-1:0] elig, busy;
  logic [EXP_LAT:0] tag_v;
  logic [PW-1:0]    tag_i [EXP_LAT+1];
  logic             hit;
  // a credit returning this cycle may be reused at once, so a full requester can still issue
  always_comb begin
    elig = '0;
    busy = '0;
    for (int i = 0; i < N_REQ; i++) begin
      elig[i] = req_valid[i] & ((cnt[i] < CW'(MAX_OUT)) | rsp_valid[i]);
      busy[i] = cnt[i] != '0;
    end
  end
  // grant the first eligible requester at or after ptr, wrapping around
  always_comb begin
    req_ready = '0;
    g = '0;
    idx = '0;
    hit = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = PW'((int'(ptr) + k) % N_REQ);
      if (!hit && elig[idx]) begin
        hit = 1'b1;
        g = idx;
      end
    end
    req_ready[g] = hit;
  end
  // register the accepted operands toward the exp unit and advance the pointer past the winner
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= '0;
      exp_req <= 1'b0;
      exp_tn <= '0;
      exp_td <= '0;
    end else begin
      exp_req <= hit;
      if (hit) begin
        ptr <= (int'(g) == N_REQ - 1) ? '0 : g + 1'b1;
        exp_tn <= req_tn[g*wTn +: wTn];
        exp_td <= req_td[g*wTd +: wTd];
      end
    end
  end
  // owner tags travel alongside the exp pipeline and steer each result back to its requester
  always_ff @(posedge clk) begin
    if (reset) begin
      tag_v <= '0;
      rsp_valid <= '0;
      rsp_result <= '0;
      for (int k = 0; k <= EXP_LAT; k++) tag_i[k] <= '0;
    end else begin
      tag_v <= {tag_v[EXP_LAT-1:0], hit};
      tag_i[0] <= g;
      for (int k = 1; k <= EXP_LAT; k++) tag_i[k] <= tag_i[k-1];
      rsp_valid <= tag_v[EXP_LAT] ? N_REQ'(1) << tag_i[EXP_LAT] : '0;
      rsp_result <= tag_v[EXP_LAT] ? exp_result : rsp_result;
    end
  end
  // outstanding count per requester: up on accept, down on response
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_REQ; i++)
      cnt[i] <= reset ? '0 : cnt[i] + CW'(req_ready[i]) - CW'(rsp_valid[i]);
  end
  assign idle = ~|tag_v & ~|busy & ~|req_valid & ~exp_req;
endmodule

// File: tb/tb_exp_req_sched.sv
// tb_exp_req_sched: randomized and directed checks of exp_req_sched against a transaction-level model
module tb_exp_req_sched;
  localparam int N = 4, LAT = 8, MO = 2, DEPTH = 4096;
  logic clk = 0, reset = 1;
  logic [N-1:0] req_valid = '0, req_ready;
  logic [N*6-1:0] req_tn = '0, req_td = '0;
  logic exp_req, idle;
  logic [5:0] exp_tn, exp_td;
  logic [7:0] exp_result, rsp_result;
  logic [N-1:0] rsp_valid;
  logic [7:0] pipe [LAT];
  int cyc = 0, mptr = 0, nvec = 0, errs = 0;
  int mcnt [N];
  bit pend [N];
  logic [5:0] ptn [N], ptd [N];
  bit iss_v [DEPTH];
  logic [5:0] iss_tn [DEPTH], iss_td [DEPTH];
  int rsp_g [DEPTH];
  logic [7:0] rsp_r [DEPTH];
  logic [5:0] last_tn = '0, last_td = '0;

  always #5 clk = ~clk;

  exp_req_sched #(.N_REQ(N), .wTn(6), .wTd(6), .wRES(8), .EXP_LAT(LAT), .MAX_OUT(MO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_tn(req_tn), .req_td(req_td), .exp_req(exp_req), .exp_tn(exp_tn), .exp_td(exp_td),
    .exp_result(exp_result), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .idle(idle));

  // stub exp unit: result {tn[3:0], td[3:0]} valid LAT cycles after the request cycle
  always @(posedge clk) begin
    if (reset) for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    else begin
      pipe[0] <= {exp_tn[3:0], exp_td[3:0]};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign exp_result = pipe[LAT-1];

  task automatic cycle(input logic [N-1:0] nm, input bit fixed);
    int g, rg, tot;
    logic [N-1:0] erdy, ersp, pv;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && nm[i]) begin
        pend[i] = 1;
        ptn[i] = fixed ? 6'(i) : 6'($urandom);
        ptd[i] = fixed ? 6'(i + 1) : 6'($urandom);
      end
      req_valid[i] = pend[i];
      req_tn[i*6 +: 6] = ptn[i];
      req_td[i*6 +: 6] = ptd[i];
    end
    rg = rsp_g[cyc];
    g = -1;
    for (int k = 0; k < N; k++)
      if (g < 0 && pend[(mptr + k) % N] && (mcnt[(mptr + k) % N] < MO || rg == (mptr + k) % N))
        g = (mptr + k) % N;
    erdy = '0;
    if (g >= 0) erdy[g] = 1'b1;
    ersp = '0;
    if (rg >= 0) ersp[rg] = 1'b1;
    tot = 0;
    pv = '0;
    for (int i = 0; i < N; i++) begin
      tot += mcnt[i];
      pv[i] = pend[i];
    end
    if (iss_v[cyc]) begin
      last_tn = iss_tn[cyc];
      last_td = iss_td[cyc];
    end
    @(negedge clk);
    nvec++;
    if (req_ready !== erdy) begin errs++; $display("FAIL req_ready cyc=%0d got=%b want=%b", cyc, req_ready, erdy); end
    nvec++;
    if (exp_req !== iss_v[cyc]) begin errs++; $display("FAIL exp_req cyc=%0d got=%b want=%b", cyc, exp_req, iss_v[cyc]); end
    nvec++;
    if (exp_tn !== last_tn || exp_td !== last_td)
      begin errs++; $display("FAIL exp_operands cyc=%0d got=%h/%h want=%h/%h", cyc, exp_tn, exp_td, last_tn, last_td); end
    nvec++;
    if (rsp_valid !== ersp) begin errs++; $display("FAIL rsp_valid cyc=%0d got=%b want=%b", cyc, rsp_valid, ersp); end
    if (rg >= 0) begin
      nvec++;
      if (rsp_result !== rsp_r[cyc]) begin errs++; $display("FAIL rsp_result cyc=%0d got=%h want=%h", cyc, rsp_result, rsp_r[cyc]); end
    end
    nvec++;
    if (idle !== (tot == 0 && pv == '0)) begin errs++; $display("FAIL idle cyc=%0d got=%b want=%b", cyc, idle, tot == 0 && pv == '0); end
    @(posedge clk); #1;
    if (g >= 0) begin
      pend[g] = 0;
      mcnt[g]++;
      iss_v[cyc+1] = 1;
      iss_tn[cyc+1] = ptn[g];
      iss_td[cyc+1] = ptd[g];
      rsp_g[cyc+LAT+2] = g;
      rsp_r[cyc+LAT+2] = {ptn[g][3:0], ptd[g][3:0]};
      mptr = (g + 1) % N;
    end
    if (rg >= 0) mcnt[rg]--;
    cyc++;
  endtask

  task automatic do_reset(input int n);
    reset = 1;
    req_valid = '0;
    for (int i = 0; i < N; i++) begin pend[i] = 0; mcnt[i] = 0; end
    repeat (n) @(posedge clk);
    #1 reset = 0;
    cyc += n;
    for (int k = cyc; k < DEPTH; k++) begin iss_v[k] = 0; rsp_g[k] = -1; end
    mptr = 0;
    last_tn = '0;
    last_td = '0;
  endtask

  task automatic drain();
    repeat (14) cycle('0, 0);
  endtask

  task automatic test_reset();
    do_reset(2);
    @(negedge clk);
    nvec++;
    if ({exp_req, exp_tn, exp_td} !== '0) begin errs++; $display("FAIL reset_exp got=%b/%h/%h want=0/00/00", exp_req, exp_tn, exp_td); end
    nvec++;
    if (rsp_valid !== '0 || rsp_result !== '0) begin errs++; $display("FAIL reset_rsp got=%b/%h want=0000/00", rsp_valid, rsp_result); end
    nvec++;
    if (idle !== 1'b1 || req_ready !== '0) begin errs++; $display("FAIL reset_idle got=%b/%b want=1/0000", idle, req_ready); end
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic test_single();
    pend[1] = 1;
    ptn[1] = 6'd5;
    ptd[1] = 6'd3;
    repeat (13) cycle('0, 0);
  endtask

  task automatic test_all_four();
    repeat (30) cycle('1, 1);
    drain();
  endtask

  task automatic test_credit();
    repeat (20) cycle(4'b0100, 1);
    drain();
  endtask

  task automatic test_wrap();
    repeat (6) cycle(4'b1001, 1);
    drain();
  endtask

  task automatic test_reset_mid();
    cycle(4'b0111, 0);
    repeat (4) cycle('0, 0);
    do_reset(1);
    repeat (15) cycle('0, 0);
    cycle(4'b1000, 0);
    repeat (12) cycle('0, 0);
  endtask

  task automatic test_random();
    repeat (250) cycle(N'($urandom), 0);
    repeat (150) cycle(N'($urandom) & N'($urandom), 0);
    drain();
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) begin iss_v[k] = 0; rsp_g[k] = -1; end
    test_reset();
    test_single();
    test_all_four();
    test_credit();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, errs);
    $finish;
  end
endmodule
